ol_pwm_multi: RTL and testbench

OL_PWM_MULTI -- requirements
Module: ol_pwm_multi

---
 rtl/ol_pwm_multi.sv | 171 +++++++++++++++++
 tb/tb_ol_pwm_multi.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ol_pwm_multi.sv
// Multi-phase interleaved PWM generator with dead time, period-aligned shadow
// registers and an optional soft-start ramp of the applied duty code.
module ol_pwm_multi #(
  parameter int PERIOD = 1000,
  parameter int CNT_W  = 11,
  parameter int DUTY_W = 8,
  parameter int DT_W   = 5,
  parameter int N_PH   = 2,
  parameter int SS_PER = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_ss_en,
  input  logic [DUTY_W-1:0] i_duty,
  input  logic [DT_W-1:0]   i_dt1,
  input  logic [DT_W-1:0]   i_dt2,
  output logic [N_PH-1:0]   o_c1,
  output logic [N_PH-1:0]   o_c2,
  output logic [DUTY_W-1:0] o_duty_act,
  output logic              o_ss_done,
  output logic              o_pstart
);

  localparam int PW = CNT_W + DUTY_W;
  localparam int XW = ((CNT_W > DT_W) ? CNT_W : DT_W) + 2;
  localparam int SW = (SS_PER > 1) ? $clog2(SS_PER) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(PERIOD - 1);
  localparam logic [XW-1:0]    PER_X   = XW'(PERIOD);
  localparam logic [PW-1:0]    PER_P   = PW'(PERIOD);
  localparam logic [SW-1:0]    SS_LAST = SW'(SS_PER - 1);

  typedef enum logic [1:0] {IDLE, SS, RUN} state_t;

  state_t            state_q, state_d;
  logic              en_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DT_W-1:0]   dt1_q, dt1_d;
  logic [DT_W-1:0]   dt2_q, dt2_d;
  logic [CNT_W-1:0]  ton_q, ton_d;
  logic [SW-1:0]     ss_cnt_q, ss_cnt_d;
  logic              ss_done_q, ss_done_d;
  logic [N_PH-1:0]   c1_q, c1_d;
  logic [N_PH-1:0]   c2_q, c2_d;

  logic              en_rise;
  logic              wrap;
  logic              active;
  logic [PW-1:0]     prod;
  logic [XW-1:0]     ph;

  assign en_rise = i_en & ~en_q;
  assign wrap    = (cnt_q == LAST);
  // Gates drop on the edge that samples i_en low, not one cycle later.
  assign active  = (state_q != IDLE) && i_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    duty_d    = duty_q;
    dt1_d     = dt1_q;
    dt2_d     = dt2_q;
    ss_cnt_d  = ss_cnt_q;
    ss_done_d = ss_done_q;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        duty_d    = '0;
        dt1_d     = '0;
        dt2_d     = '0;
        ss_cnt_d  = '0;
        ss_done_d = 1'b0;
        if (en_rise) begin
          dt1_d = i_dt1;
          dt2_d = i_dt2;
          if (i_ss_en) begin
            state_d = SS;
          end else begin
            state_d   = RUN;
            duty_d    = i_duty;
            ss_done_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) begin
          dt1_d = i_dt1;
          dt2_d = i_dt2;
          if (state_q == RUN) begin
            duty_d = i_duty;
          end else begin
            if (i_duty < duty_q) begin
              duty_d   = i_duty;
              ss_cnt_d = '0;
            end else if (ss_cnt_q == SS_LAST) begin
              ss_cnt_d = '0;
              if (duty_q != i_duty) duty_d = duty_q + 1'b1;
            end else begin
              ss_cnt_d = ss_cnt_q + 1'b1;
            end
            if (duty_d == i_duty) begin
              state_d   = RUN;
              ss_done_d = 1'b1;
            end
          end
        end
        if (!i_en) begin
          state_d   = IDLE;
          cnt_d     = '0;
          duty_d    = '0;
          dt1_d     = '0;
          dt2_d     = '0;
          ss_cnt_d  = '0;
          ss_done_d = 1'b0;
        end
      end
    endcase
    // ton always tracks the duty it will be paired with in the shadow set.
    prod  = PW'(duty_d) * PER_P;
    ton_d = prod[PW-1:DUTY_W];
  end

  always_comb begin
    c1_d = '0;
    c2_d = '0;
    ph   = '0;
    for (int unsigned k = 0; k < N_PH; k++) begin
      ph = XW'(cnt_q) + XW'((PERIOD * k) / N_PH);
      if (ph >= PER_X) ph = ph - PER_X;
      c1_d[k] = active && (ph >= XW'(dt1_q)) && (ph < XW'(ton_q));
      c2_d[k] = active && (ph >= XW'(ton_q) + XW'(dt2_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      en_q      <= 1'b1;
      cnt_q     <= '0;
      duty_q    <= '0;
      dt1_q     <= '0;
      dt2_q     <= '0;
      ton_q     <= '0;
      ss_cnt_q  <= '0;
      ss_done_q <= 1'b0;
      c1_q      <= '0;
      c2_q      <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= i_en;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      dt1_q     <= dt1_d;
      dt2_q     <= dt2_d;
      ton_q     <= ton_d;
      ss_cnt_q  <= ss_cnt_d;
      ss_done_q <= ss_done_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
    end
  end

  assign o_c1       = c1_q;
  assign o_c2       = c2_q;
  assign o_duty_act = duty_q;
  assign o_ss_done  = ss_done_q;
  assign o_pstart   = (state_q != IDLE) && wrap;

endmodule

// File: tb/tb_ol_pwm_multi.sv
// Directed bench for ol_pwm_multi: PERIOD=100, two phases, SS_PER=2.
module tb_ol_pwm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_en;
  logic       i_ss_en;
  logic [7:0] i_duty;
  logic [4:0] i_dt1;
  logic [4:0] i_dt2;
  logic [1:0] o_c1;
  logic [1:0] o_c2;
  logic [7:0] o_duty_act;
  logic       o_ss_done;
  logic       o_pstart;

  int vec_cnt = 0;
  int err_cnt = 0;

  ol_pwm_multi #(
    .PERIOD(100),
    .CNT_W (11),
    .DUTY_W(8),
    .DT_W  (5),
    .N_PH  (2),
    .SS_PER(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_en      (i_en),
    .i_ss_en   (i_ss_en),
    .i_duty    (i_duty),
    .i_dt1     (i_dt1),
    .i_dt2     (i_dt2),
    .o_c1      (o_c1),
    .o_c2      (o_c2),
    .o_duty_act(o_duty_act),
    .o_ss_done (o_ss_done),
    .o_pstart  (o_pstart)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    vec_cnt++;
    if ({o_c1, o_c2, o_duty_act, o_ss_done, o_pstart} !== 14'd0) begin
      err_cnt++;
      $display("FAIL %s: got c1=%b c2=%b duty=%0d done=%b pstart=%b want all 0",
               nm, o_c1, o_c2, o_duty_act, o_ss_done, o_pstart);
    end
  endtask

  // One full period starting right after the edge that set cnt=0; windows from
  // the hand-computed ton/dead times. Optionally changes inputs mid-period.
  task automatic check_period(input string nm, input int ton, input int dt1,
                              input int dt2, input int chg,
                              input logic [7:0] nd, input logic [4:0] ndt1);
    logic [1:0] e1, e2;
    int ph;
    for (int i = 0; i < 100; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        ph    = (i + 50 * k) % 100;
        e1[k] = (ph >= dt1) && (ph < ton);
        e2[k] = (ph >= ton + dt2);
      end
      vec_cnt++;
      if ({o_c1, o_c2} !== {e1, e2}) begin
        err_cnt++;
        $display("FAIL %s gates cnt=%0d: got c1=%b c2=%b want c1=%b c2=%b",
                 nm, i, o_c1, o_c2, e1, e2);
      end
      vec_cnt++;
      if (o_pstart !== (i == 98)) begin
        err_cnt++;
        $display("FAIL %s pstart i=%0d: got %b want %b", nm, i, o_pstart, i == 98);
      end
      if (i == chg) begin
        i_duty = nd;
        i_dt1  = ndt1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_en = 1'b1; i_ss_en = 1'b0;
    i_duty = 8'd128; i_dt1 = 5'd3; i_dt2 = 5'd4;
    tick(); tick();
    check_idle("reset");
    rst = 1'b0;
    repeat (3) tick();
    check_idle("no_edge_after_reset");
  endtask

  task automatic test_basic();
    i_en = 1'b0;
    tick();
    i_en = 1'b1;
    tick();
    vec_cnt++;
    if (o_duty_act !== 8'd128 || o_ss_done !== 1'b1 || o_c1 !== 2'b00) begin
      err_cnt++;
      $display("FAIL basic_start: got duty=%0d done=%b c1=%b want 128 1 00",
               o_duty_act, o_ss_done, o_c1);
    end
    check_period("basic_p1", 50, 3, 4, -1, 8'd128, 5'd3);
    check_period("basic_p2", 50, 3, 4, -1, 8'd128, 5'd3);
  endtask

  task automatic test_shadow();
    check_period("shadow_hold", 50, 3, 4, 20, 8'd64, 5'd3);
    vec_cnt++;
    if (o_duty_act !== 8'd64) begin
      err_cnt++;
      $display("FAIL shadow_duty: got %0d want 64", o_duty_act);
    end
    check_period("shadow_new", 25, 3, 4, 50, 8'd0, 5'd3);
  endtask

  task automatic test_degenerate();
    check_period("duty_zero", 0, 3, 4, 10, 8'd255, 5'd3);
    check_period("duty_full", 99, 3, 4, 70, 8'd64, 5'd31);
    check_period("dt1_large", 25, 31, 4, -1, 8'd64, 5'd31);
  endtask

  task automatic test_abort();
    repeat (40) tick();
    vec_cnt++;
    if (o_c1 !== 2'b00 || o_c2 !== 2'b11) begin
      err_cnt++;
      $display("FAIL abort_pre: got c1=%b c2=%b want 00 11", o_c1, o_c2);
    end
    i_en = 1'b0;
    tick();
    check_idle("abort_next");
    tick();
    check_idle("abort_next2");
  endtask

  task automatic test_softstart();
    i_duty = 8'd4; i_dt1 = 5'd3; i_dt2 = 5'd4; i_ss_en = 1'b1;
    i_en = 1'b1;
    tick();
    vec_cnt++;
    if (o_duty_act !== 8'd0 || o_ss_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL ss_start: got duty=%0d done=%b want 0 0", o_duty_act, o_ss_done);
    end
    for (int w = 1; w <= 8; w++) begin
      for (int i = 0; i < 99; i++) begin
        tick();
        vec_cnt++;
        if ((o_c1 & o_c2) !== 2'b00) begin
          err_cnt++;
          $display("FAIL ss_overlap w=%0d: got c1=%b c2=%b want disjoint", w, o_c1, o_c2);
        end
      end
      vec_cnt++;
      if (o_ss_done !== 1'b0) begin
        err_cnt++;
        $display("FAIL ss_done_early w=%0d: got %b want 0", w, o_ss_done);
      end
      tick();
      vec_cnt++;
      if (o_duty_act !== 8'(w / 2) || o_ss_done !== (w == 8)) begin
        err_cnt++;
        $display("FAIL ss_wrap w=%0d: got duty=%0d done=%b want %0d %b",
                 w, o_duty_act, o_ss_done, w / 2, w == 8);
      end
    end
    i_duty = 8'd10;
    repeat (100) tick();
    vec_cnt++;
    if (o_duty_act !== 8'd10 || o_ss_done !== 1'b1) begin
      err_cnt++;
      $display("FAIL run_follow: got duty=%0d done=%b want 10 1", o_duty_act, o_ss_done);
    end
  endtask

  task automatic test_ss_zero();
    i_en = 1'b0;
    tick();
    i_duty = 8'd0; i_ss_en = 1'b1; i_en = 1'b1;
    tick();
    repeat (99) tick();
    vec_cnt++;
    if (o_ss_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL ss_zero_early: got %b want 0", o_ss_done);
    end
    tick();
    vec_cnt++;
    if (o_ss_done !== 1'b1 || o_duty_act !== 8'd0) begin
      err_cnt++;
      $display("FAIL ss_zero_done: got done=%b duty=%0d want 1 0", o_ss_done, o_duty_act);
    end
  endtask

  task automatic test_rst_mid_ss();
    i_en = 1'b0;
    tick();
    i_duty = 8'd4; i_ss_en = 1'b1; i_en = 1'b1;
    tick();
    repeat (150) tick();
    vec_cnt++;
    if (o_c2 !== 2'b11 || o_c1 !== 2'b00) begin
      err_cnt++;
      $display("FAIL rst_pre: got c1=%b c2=%b want 00 11", o_c1, o_c2);
    end
    rst = 1'b1;
    tick();
    check_idle("rst_mid_ss");
    rst = 1'b0;
    repeat (5) tick();
    check_idle("rst_needs_edge");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shadow();
    test_degenerate();
    test_abort();
    test_softstart();
    test_ss_zero();
    test_rst_mid_ss();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
